lsu_avalon_master: RTL

- Sequential successor to the combinational load/store unit.
- Accepts one load/store request from the core, runs a full Avalon-MM master transaction with waitrequest and readdatavalid, and shifts byte lanes by the address offset.
- Sign- or zero-extends load data and returns it with a one-cycle Done pulse.
- Sits between the core's memory stage and the data-memory Avalon interconnect; generalised to DATAWIDTH 32 or 64.

---
 rtl/lsu_avalon_master_if.sv | 44 ++++
 rtl/lsu_avalon_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_avalon_master_if.sv
// Core-side request/response and Avalon-MM master signals of the LSU.
// master: LSU view; slave: core + interconnect view.
interface lsu_avalon_master_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32
);
    localparam int BEWIDTH = DATAWIDTH / 8;

    logic                 LSUM_Start;
    logic                 LSUM_Store;
    logic [2:0]           LSUM_Funct3_InBUS;
    logic [ADDRWIDTH-1:0] LSUM_Addr_InBUS;
    logic [DATAWIDTH-1:0] LSUM_WrData_InBUS;
    logic                 LSUM_Busy;
    logic                 LSUM_Done;
    logic [DATAWIDTH-1:0] LSUM_LoadData_OutBUS;
    logic                 LSUM_Misaligned;
    logic [ADDRWIDTH-1:0] AVM_Address_OutBUS;
    logic [BEWIDTH-1:0]   AVM_Byteenable_OutBUS;
    logic                 AVM_Read;
    logic                 AVM_Write;
    logic [DATAWIDTH-1:0] AVM_WriteData_OutBUS;
    logic [DATAWIDTH-1:0] AVM_ReadData_InBUS;
    logic                 AVM_WaitRequest;
    logic                 AVM_ReadDataValid;

    modport master (
        input  LSUM_Start, LSUM_Store, LSUM_Funct3_InBUS,
        input  LSUM_Addr_InBUS, LSUM_WrData_InBUS,
        input  AVM_ReadData_InBUS, AVM_WaitRequest, AVM_ReadDataValid,
        output LSUM_Busy, LSUM_Done, LSUM_LoadData_OutBUS, LSUM_Misaligned,
        output AVM_Address_OutBUS, AVM_Byteenable_OutBUS,
        output AVM_Read, AVM_Write, AVM_WriteData_OutBUS
    );

    modport slave (
        output LSUM_Start, LSUM_Store, LSUM_Funct3_InBUS,
        output LSUM_Addr_InBUS, LSUM_WrData_InBUS,
        output AVM_ReadData_InBUS, AVM_WaitRequest, AVM_ReadDataValid,
        input  LSUM_Busy, LSUM_Done, LSUM_LoadData_OutBUS, LSUM_Misaligned,
        input  AVM_Address_OutBUS, AVM_Byteenable_OutBUS,
        input  AVM_Read, AVM_Write, AVM_WriteData_OutBUS
    );
endinterface

// File: rtl/lsu_avalon_master.sv
// Sequential load/store unit running one Avalon-MM master transaction per request.
// Define LSUM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsu_avalon_master #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32
) (
    input  logic LSUM_CLOCK_50,
    input  logic LSUM_RESET_InLow,
    lsu_avalon_master_if.master bus
);
    localparam int BEWIDTH = DATAWIDTH / 8;
    localparam int OFFW    = (DATAWIDTH == 64) ? 3 : 2;

    typedef enum logic [1:0] {IDLE, REQ, RDWAIT, DONE} state_t;

    state_t               state;
    state_t               state_nx;
    logic                 store_r;
    logic [2:0]           f3_r;
    logic [ADDRWIDTH-1:0] addr_r;
    logic [DATAWIDTH-1:0] wdata_r;
    logic [DATAWIDTH-1:0] ldata_r;
    logic                 mis_r;
    logic                 start_mis;
    logic                 load_en;
    logic [1:0]           sz_r;
    logic [OFFW-1:0]      off_r;
    logic [BEWIDTH-1:0]   be_base;
    logic [DATAWIDTH-1:0] rd_shift;
    logic [DATAWIDTH-1:0] rd_ext;

    // A dword request on a 32-bit bus degrades to a word access.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        if (DATAWIDTH == 32 && f3[1:0] == 2'b11) return 2'b10;
        return f3[1:0];
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [OFFW-1:0] low_mask(input logic [1:0] sz);
        logic [OFFW-1:0] m;
        unique case (sz)
            2'b00:   m = '0;
            2'b01:   m = OFFW'(1);
            2'b10:   m = OFFW'(3);
            default: m = OFFW'(7);
        endcase
        return m;
    endfunction

    // Keep the access-size bytes and fill the rest with sign or zeros.
    function automatic logic [DATAWIDTH-1:0] extend(
        input logic [DATAWIDTH-1:0] d,
        input logic [1:0]           sz,
        input logic                 uns
    );
        logic [DATAWIDTH-1:0] m;
        logic                 s;
        unique case (sz)
            2'b00: begin
                m = DATAWIDTH'(8'hFF);
                s = d[7];
            end
            2'b01: begin
                m = DATAWIDTH'(16'hFFFF);
                s = d[15];
            end
            2'b10: begin
                m = DATAWIDTH'(32'hFFFF_FFFF);
                s = d[31];
            end
            default: begin
                m = '1;
                s = 1'b0;
            end
        endcase
        return (d & m) | ({DATAWIDTH{s & ~uns}} & ~m);
    endfunction

    assign sz_r = size_of(f3_r);

`ifdef LSUM_MISALIGN_TRAP_EN
    assign off_r     = addr_r[OFFW-1:0];
    assign start_mis = |(bus.LSUM_Addr_InBUS[OFFW-1:0]
                         & low_mask(size_of(bus.LSUM_Funct3_InBUS)));
`else
    assign off_r     = addr_r[OFFW-1:0] & ~low_mask(sz_r);
    assign start_mis = 1'b0;
`endif

    assign rd_shift = bus.AVM_ReadData_InBUS >> {off_r, 3'b000};
    assign rd_ext   = extend(rd_shift, sz_r, f3_r[2]);

    // Unshifted lane mask for the access size.
    always_comb begin
        be_base = '0;
        unique case (sz_r)
            2'b00:   be_base = BEWIDTH'(8'h01);
            2'b01:   be_base = BEWIDTH'(8'h03);
            2'b10:   be_base = BEWIDTH'(8'h0F);
            default: be_base = '1;
        endcase
    end

    // Next-state logic and load-capture strobe.
    always_comb begin
        state_nx = state;
        load_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.LSUM_Start) state_nx = start_mis ? DONE : REQ;
            end
            REQ: begin
                if (!bus.AVM_WaitRequest) begin
                    if (store_r) begin
                        state_nx = DONE;
                    end else if (bus.AVM_ReadDataValid) begin
                        load_en  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (bus.AVM_ReadDataValid) begin
                    load_en  = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Avalon request outputs, driven only from registers while in REQ.
    always_comb begin
        bus.AVM_Read              = 1'b0;
        bus.AVM_Write             = 1'b0;
        bus.AVM_Address_OutBUS    = '0;
        bus.AVM_Byteenable_OutBUS = '0;
        bus.AVM_WriteData_OutBUS  = '0;
        if (state == REQ) begin
            bus.AVM_Read              = ~store_r;
            bus.AVM_Write             = store_r;
            bus.AVM_Address_OutBUS    = {addr_r[ADDRWIDTH-1:OFFW], {OFFW{1'b0}}};
            bus.AVM_Byteenable_OutBUS = be_base << off_r;
            bus.AVM_WriteData_OutBUS  = wdata_r << {off_r, 3'b000};
        end
    end

    assign bus.LSUM_Busy            = (state != IDLE);
    assign bus.LSUM_Done            = (state == DONE);
    assign bus.LSUM_Misaligned      = (state == DONE) & mis_r;
    assign bus.LSUM_LoadData_OutBUS = ldata_r;

    // State register.
    always_ff @(posedge LSUM_CLOCK_50 or negedge LSUM_RESET_InLow) begin
        if (!LSUM_RESET_InLow) state <= IDLE;
        else                   state <= state_nx;
    end

    // Request capture in IDLE and load result capture on read data.
    always_ff @(posedge LSUM_CLOCK_50 or negedge LSUM_RESET_InLow) begin
        if (!LSUM_RESET_InLow) begin
            store_r <= 1'b0;
            f3_r    <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            ldata_r <= '0;
            mis_r   <= 1'b0;
        end else begin
            if (state == IDLE && bus.LSUM_Start) begin
                store_r <= bus.LSUM_Store;
                f3_r    <= bus.LSUM_Funct3_InBUS;
                addr_r  <= bus.LSUM_Addr_InBUS;
                wdata_r <= bus.LSUM_WrData_InBUS;
                mis_r   <= start_mis;
            end
            if (load_en) ldata_r <= rd_ext;
        end
    end
endmodule
